// File: rtl/ibuf_sync_filter_pkg.sv
// ============================================================================
// Module   : ibuf_filter_pkg
// Contents : shared types and widths for the pad-input sync/debounce filter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ibuf_filter_pkg;

   typedef enum logic {IDLE, FILTER} filter_state_t;

   localparam int GLITCH_CNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/ibuf_sync_filter_if.sv
// ============================================================================
// Module   : ibuf_sync_filter_if
// Contents : pin-side and status signals of the sync/debounce filter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ibuf_sync_filter_if;
   import ibuf_filter_pkg::*;

   logic                    i_async;
   logic                    i_glitch_clr;
   logic                    o_level;
   logic                    o_rise;
   logic                    o_fall;
   logic                    o_busy;
   logic [GLITCH_CNT_W-1:0] o_glitch_cnt;

   modport master (
      output i_async, i_glitch_clr,
      input  o_level, o_rise, o_fall, o_busy, o_glitch_cnt
   );

   modport slave (
      input  i_async, i_glitch_clr,
      output o_level, o_rise, o_fall, o_busy, o_glitch_cnt
   );

endinterface

`default_nettype wire

// File: rtl/ibuf_sync_filter_sync_ff_chain.sv
// ============================================================================
// Module   : sync_ff_chain
// Contents : plain single-bit flop chain for clock-domain entry
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_ff_chain #(
   parameter int   STAGES = 2,
   parameter logic INIT   = 1'b0
) (
   input  wire logic i_clk,
   input  wire logic i_rst,
   input  wire logic i_d,
   output logic      o_q
);

   // Kept as a bare shift register so the tools can place the flops adjacently.
   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync <= {STAGES{INIT}};
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/ibuf_sync_filter.sv
// ============================================================================
// Module   : ibuf_sync_filter
// Contents : pad-input synchronizer + counter debounce with edge strobes
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ibuf_sync_filter
   import ibuf_filter_pkg::*;
#(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 16,
   parameter int   CNT_WIDTH       = 16,
   parameter logic RESET_LEVEL     = 1'b0
) (
   input  wire logic          i_clk,
   input  wire logic          i_rst,
   ibuf_sync_filter_if.slave  pin_if
);

   localparam logic [CNT_WIDTH-1:0]    c_cnt_last   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [GLITCH_CNT_W-1:0] c_glitch_max = '1;

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
      $error("ibuf_sync_filter: SYNC_STAGES must be 2..4");
   end
   if (DEBOUNCE_CYCLES < 1 || 64'(DEBOUNCE_CYCLES) > (64'd1 << CNT_WIDTH)) begin : g_bad_debounce
      $error("ibuf_sync_filter: DEBOUNCE_CYCLES out of range for CNT_WIDTH");
   end

   logic                    w_s;
   filter_state_t           r_state, w_state_nxt;
   logic [CNT_WIDTH-1:0]    r_cnt, w_cnt_nxt;
   logic                    r_level, w_level_nxt;
   logic                    r_rise, w_rise_nxt;
   logic                    r_fall, w_fall_nxt;
   logic                    w_glitch;
   logic [GLITCH_CNT_W-1:0] r_glitch_cnt;

   sync_ff_chain #(
      .STAGES (SYNC_STAGES),
      .INIT   (RESET_LEVEL)
   ) u_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (pin_if.i_async),
      .o_q   (w_s)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_level <= RESET_LEVEL;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_level <= w_level_nxt;
         r_rise  <= w_rise_nxt;
         r_fall  <= w_fall_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_level_nxt = r_level;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      w_glitch    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_s != r_level) begin
               w_state_nxt = FILTER;
               w_cnt_nxt   = '0;
            end
         end
         FILTER: begin
            if (w_s == r_level) begin
               // Input fell back before the window closed: reject it.
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
               w_glitch    = 1'b1;
            end else if (r_cnt == c_cnt_last) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
               w_level_nxt = w_s;
               w_rise_nxt  = w_s;
               w_fall_nxt  = ~w_s;
            end else begin
               w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Clear wins over a same-cycle increment.
   always_ff @(posedge i_clk) begin
      if (i_rst || pin_if.i_glitch_clr) begin
         r_glitch_cnt <= '0;
      end else if (w_glitch && r_glitch_cnt != c_glitch_max) begin
         r_glitch_cnt <= r_glitch_cnt + GLITCH_CNT_W'(1);
      end
   end

   assign pin_if.o_level      = r_level;
   assign pin_if.o_rise       = r_rise;
   assign pin_if.o_fall       = r_fall;
   assign pin_if.o_busy       = (r_state == FILTER);
   assign pin_if.o_glitch_cnt = r_glitch_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ibuf_sync_filter.sv
// ============================================================================
// Module   : tb_ibuf_sync_filter
// Contents : directed + randomized bench for ibuf_sync_filter (2 sync, 4 debounce)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ibuf_sync_filter;

   localparam int SYNC = 2;
   localparam int DEB  = 4;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   ibuf_sync_filter_if bus ();

   ibuf_sync_filter #(
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DEB),
      .CNT_WIDTH       (16),
      .RESET_LEVEL     (1'b0)
   ) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .pin_if (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: s is the pin seen SYNC edges ago; level flips once s has
   // disagreed with it on DEB+1 consecutive edges, a shorter run is a glitch.
   logic [SYNC-1:0] m_hist;
   logic            m_level, m_rise, m_fall;
   int              m_run;
   logic [7:0]      m_glitch;

   task automatic tick(input logic pin, input logic clr, input logic rst_v);
      logic s;
      bus.i_async      = pin;
      bus.i_glitch_clr = clr;
      rst              = rst_v;
      @(posedge clk);
      if (rst_v) begin
         m_hist = '0; m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
         m_run = 0; m_glitch = 8'd0;
      end else begin
         s = m_hist[SYNC-1];
         m_rise = 1'b0;
         m_fall = 1'b0;
         if (s != m_level) begin
            m_run++;
            if (m_run == DEB + 1) begin
               m_level = s;
               m_rise  = s;
               m_fall  = ~s;
               m_run   = 0;
            end
         end else begin
            if (m_run > 0 && m_glitch != 8'd255 && !clr) m_glitch++;
            m_run = 0;
         end
         if (clr) m_glitch = 8'd0;
         m_hist = {m_hist[SYNC-2:0], pin};
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [11:0] exp;
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1);
      n_tests++;
      if ({bus.o_level, bus.o_rise, bus.o_fall, bus.o_busy, bus.o_glitch_cnt} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_state: got %h expected %h",
                  {bus.o_level, bus.o_rise, bus.o_fall, bus.o_busy, bus.o_glitch_cnt}, 12'h000);
      end
      for (int k = 0; k < 8; k++) begin
         tick(1'b1, 1'b0, 1'b0);
         exp = {k >= 6, k == 6, 1'b0, (k >= 2 && k <= 5), 8'd0};
         n_tests++;
         if ({bus.o_level, bus.o_rise, bus.o_fall, bus.o_busy, bus.o_glitch_cnt} !== exp) begin
            n_fail++;
            $display("FAIL reset_release k=%0d: got %h expected %h", k,
                     {bus.o_level, bus.o_rise, bus.o_fall, bus.o_busy, bus.o_glitch_cnt}, exp);
         end
      end
   endtask

   task automatic test_clean_rise();
      logic [11:0] exp;
      for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         tick(1'b1, 1'b0, 1'b0);
         exp = {k >= 6, k == 6, 1'b0, (k >= 2 && k <= 5), 8'd0};
         n_tests++;
         if ({bus.o_level, bus.o_rise, bus.o_fall, bus.o_busy, bus.o_glitch_cnt} !== exp) begin
            n_fail++;
            $display("FAIL clean_rise k=%0d: got %h expected %h", k,
                     {bus.o_level, bus.o_rise, bus.o_fall, bus.o_busy, bus.o_glitch_cnt}, exp);
         end
      end
   endtask

   task automatic test_clean_fall();
      logic [11:0] exp;
      for (int i = 0; i < 2; i++) tick(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         tick(1'b0, 1'b0, 1'b0);
         exp = {k < 6, 1'b0, k == 6, (k >= 2 && k <= 5), 8'd0};
         n_tests++;
         if ({bus.o_level, bus.o_rise, bus.o_fall, bus.o_busy, bus.o_glitch_cnt} !== exp) begin
            n_fail++;
            $display("FAIL clean_fall k=%0d: got %h expected %h", k,
                     {bus.o_level, bus.o_rise, bus.o_fall, bus.o_busy, bus.o_glitch_cnt}, exp);
         end
      end
   endtask

   task automatic test_glitch();
      logic [11:0] exp;
      for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         tick(k < 2, 1'b0, 1'b0);
         exp = {1'b0, 1'b0, 1'b0, (k == 2 || k == 3), (k >= 4) ? 8'd1 : 8'd0};
         n_tests++;
         if ({bus.o_level, bus.o_rise, bus.o_fall, bus.o_busy, bus.o_glitch_cnt} !== exp) begin
            n_fail++;
            $display("FAIL glitch k=%0d: got %h expected %h", k,
                     {bus.o_level, bus.o_rise, bus.o_fall, bus.o_busy, bus.o_glitch_cnt}, exp);
         end
      end
   endtask

   task automatic test_saturation_clear();
      for (int p = 0; p < 300; p++)
         for (int j = 0; j < 6; j++) tick(j < 2, 1'b0, 1'b0);
      n_tests++;
      if (bus.o_glitch_cnt !== 8'd255 || bus.o_level !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch_saturate: got cnt=%0d level=%b expected cnt=255 level=0",
                  bus.o_glitch_cnt, bus.o_level);
      end
      // Clear lands on the very edge that rejects the next glitch.
      for (int j = 0; j < 6; j++) begin
         tick(j < 2, j == 4, 1'b0);
         if (j == 4) begin
            n_tests++;
            if (bus.o_glitch_cnt !== 8'd0) begin
               n_fail++;
               $display("FAIL glitch_clear_priority: got %0d expected 0", bus.o_glitch_cnt);
            end
         end
      end
      n_tests++;
      if (bus.o_glitch_cnt !== 8'd0 || bus.o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch_after_clear: got cnt=%0d busy=%b expected cnt=0 busy=0",
                  bus.o_glitch_cnt, bus.o_busy);
      end
   endtask

   task automatic test_reset_mid_filter();
      logic [11:0] exp;
      for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b1);
      n_tests++;
      if ({bus.o_level, bus.o_rise, bus.o_fall, bus.o_busy, bus.o_glitch_cnt} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_mid_filter: got %h expected %h",
                  {bus.o_level, bus.o_rise, bus.o_fall, bus.o_busy, bus.o_glitch_cnt}, 12'h000);
      end
      for (int k = 0; k < 8; k++) begin
         tick(1'b1, 1'b0, 1'b0);
         exp = {k >= 6, k == 6, 1'b0, (k >= 2 && k <= 5), 8'd0};
         n_tests++;
         if ({bus.o_level, bus.o_rise, bus.o_fall, bus.o_busy, bus.o_glitch_cnt} !== exp) begin
            n_fail++;
            $display("FAIL reset_mid_rerun k=%0d: got %h expected %h", k,
                     {bus.o_level, bus.o_rise, bus.o_fall, bus.o_busy, bus.o_glitch_cnt}, exp);
         end
      end
   endtask

   task automatic test_random();
      logic        pin;
      logic        clr;
      logic        rr;
      int          left;
      logic [11:0] exp;
      pin  = bus.i_async;
      left = 0;
      for (int i = 0; i < 3000; i++) begin
         if (left == 0) begin
            pin  = ~pin;
            left = $urandom_range(1, 8);
         end
         left--;
         clr = ($urandom_range(0, 31) == 0);
         rr  = ($urandom_range(0, 249) == 0);
         tick(pin, clr, rr);
         exp = {m_level, m_rise, m_fall, m_run != 0, m_glitch};
         n_tests++;
         if ({bus.o_level, bus.o_rise, bus.o_fall, bus.o_busy, bus.o_glitch_cnt} !== exp) begin
            n_fail++;
            $display("FAIL random cycle=%0d: got %h expected %h", i,
                     {bus.o_level, bus.o_rise, bus.o_fall, bus.o_busy, bus.o_glitch_cnt}, exp);
         end
      end
   endtask

   initial begin
      n_tests          = 0;
      n_fail           = 0;
      rst              = 1'b1;
      bus.i_async      = 1'b0;
      bus.i_glitch_clr = 1'b0;
      m_hist = '0; m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
      m_run = 0; m_glitch = 8'd0;
      @(negedge clk);
      test_reset();
      test_clean_rise();
      test_clean_fall();
      test_glitch();
      test_saturation_clear();
      test_reset_mid_filter();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ibuf_sync_filter.md
Name: ibuf_sync_filter

Overview:
- Sits directly downstream of the technology input buffer on every asynchronous pad input (GPIO, UART RX, JTAG straps, push-buttons).
- Takes the buffered but unsynchronised pin level and passes it through an N-flop synchronizer, then a counter-based debounce FSM.
- Produces a clean registered level, one-cycle rise/fall strobes, and a saturating glitch counter for diagnostics.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops (legal 2..4).
- DEBOUNCE_CYCLES, 16, consecutive cycles the synchronized value must differ from o_level before o_level updates (legal >=1).
- CNT_WIDTH, 16, debounce counter width; elaboration error if DEBOUNCE_CYCLES > 2**CNT_WIDTH.
- RESET_LEVEL, 1'b0, reset value of the synchronizer flops and o_level.

Ports:
- i_clk  in  1  system clock; all flops on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_async  in  1  pin level from the input buffer; asynchronous to i_clk.
- i_glitch_clr  in  1  synchronous clear of o_glitch_cnt.
- o_level  out  1  debounced, registered level.
- o_rise  out  1  one-cycle pulse when o_level goes 0->1.
- o_fall  out  1  one-cycle pulse when o_level goes 1->0.
- o_busy  out  1  high while the FSM is in FILTER.
- o_glitch_cnt  out  8  saturating count of rejected transitions.

Behaviour:
- Reset, sampled at a rising edge of i_clk with i_rst=1:
  - all sync flops = RESET_LEVEL, o_level = RESET_LEVEL;
  - o_rise = o_fall = o_busy = 0, cnt = 0, o_glitch_cnt = 0, state = IDLE.
- Reset mid-FILTER abandons the pending transition: no strobe, no glitch count.
- Synchronizer: i_async -> sync[0] -> ... -> sync[SYNC_STAGES-1] = s. No logic between the flops.
- FSM, two states:
  - IDLE: if s != o_level, go to FILTER with cnt <= 0; otherwise stay.
  - FILTER, s == o_level: glitch. Go to IDLE, cnt <= 0, o_glitch_cnt increments (saturates at 255).
  - FILTER, s != o_level and cnt == DEBOUNCE_CYCLES-1: o_level <= s, pulse o_rise or o_fall, go to IDLE, cnt <= 0.
  - FILTER, otherwise: cnt <= cnt+1.
- o_busy is combinational: (state == FILTER).
- o_rise and o_fall are registered, high for exactly one cycle, never both high at once.
- Latency: pin stable before capture edge E0 -> o_level updates at edge E(SYNC_STAGES + DEBOUNCE_CYCLES).
- Minimum spacing between consecutive strobes: DEBOUNCE_CYCLES+1 cycles.
- i_glitch_clr has priority over a same-cycle increment: result is 0.
- Asynchronous toggling faster than the clock produces only level changes on s. No X propagation in simulation beyond the sync chain.
- Synthesis attribute ASYNC_REG on the sync flops, placed inside the sub-module.

Decomposition:
- Package ibuf_filter_pkg holds:
  - typedef enum logic {IDLE, FILTER} filter_state_t;
  - localparam GLITCH_CNT_W = 8.
- Sub-module sync_ff_chain (parameters STAGES, INIT; ports i_clk, i_rst, i_d, o_q). It is reused by other clock-crossing single-bit paths.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Reset: hold i_rst 3 cycles with i_async=1 -> o_level=0, o_rise=o_fall=o_busy=0, o_glitch_cnt=0; after release, o_level still 0 until the debounce completes.
- Clean rise: i_async 0->1 before edge E0, held -> o_busy high after E2; o_level=1 and o_rise=1 after E6; o_rise=0 after E7.
- Glitch: i_async high for 2 cycles, then low -> o_level stays 0, no strobes, o_busy high for 2 cycles, o_glitch_cnt=1.
- Saturation and clear: 300 glitch pulses -> o_glitch_cnt=255; i_glitch_clr=1 together with a glitch -> o_glitch_cnt=0.
- Clean fall: from o_level=1, i_async 1->0 held -> o_fall one cycle at E6, o_level=0; o_rise never asserts.
- Reset mid-filter: assert i_rst at E4 during a rise -> after E4 o_busy=0, o_level=0, no o_rise; re-released with i_async=1 -> o_rise 6 edges after the first capture edge.
